booth_mul_sched: RTL and testbench
==================================

# booth_mul_sched

Two-requester scheduler for the shared Booth/Wallace mantissa multiplier. It arbitrates round-robin between two operand streams, each using a valid/ready handshake, and registers operands and mode into the multiplier. It tracks in-flight tags through the multiplier's fixed latency and buffers products in a result FIFO. A credit check guarantees that result backpressure never drops a product. Sits between the FP mantissa-prep stages (requesters) and the multiplier datapath.

## Interface
- `LAT`, 2: multiplier latency in cycles (≥1); `mul_p` is valid LAT-1 cycles after `mul_a`/`mul_b` update.
- `DEPTH`, 4: result FIFO entries (power of 2, ≥2).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 2: request valid, bit i = requester i.
- `req_ready` out 2: request accepted on an edge where valid&ready.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 23 each: mantissa operands.
- `req0_con`, `req1_con` in 1: mode, 1 = 23-bit single, 0 = 10-bit half.
- `mul_a`, `mul_b` out 23: registered operands to multiplier.
- `mul_con` out 1: registered mode to multiplier.
- `mul_error` out 1: one-cycle kill pulse to multiplier after flush.
- `mul_p` in 64: multiplier product.
- `flush` in 1: synchronous flush of all in-flight and buffered work.
- `rsp_valid` out 1: FIFO head valid.
- `rsp_ready` in 1: consumer accepts head.
- `rsp_id` out 1: requester index of head.
- `rsp_con` out 1: mode of head.
- `rsp_p` out 64: product of head.
- `busy` out 1: any tag in flight or FIFO non-empty.

## Operation
- Arbiter: `rr` pointer names the requester that gets priority; reset value 0.
  - Both valid: grant the `rr` requester.
  - One valid: grant it.
  - On each accept, `rr` ← the other requester.
- Credit: `free` = DEPTH − fifo_count − inflight_count.
- `req_ready[i]` = grant[i] & (free > 0) & !flush & rst. At most one bit is high per cycle.
- Accept (edge E0):
  - `mul_a`/`mul_b` ← operands.
  - Half mode: bits [22:10] are forced to 0.
  - `mul_con` ← mode.
  - Tag {valid, id, con} enters shift stage 1.
- No accept: `mul_a`, `mul_b` and `mul_con` hold. The tag entering stage 1 has valid=0.
- Tag shift register, stages 1..LAT:
  - At the edge where the tag leaves stage LAT, `mul_p` is written to the FIFO with id/con.
  - In half mode, `rsp_p[63:20]` is stored as 0.
- FIFO pop: on an edge with `rsp_valid`&`rsp_ready`.
  - Push and pop in the same edge are legal at any occupancy.
  - Overflow is impossible by credit. A freed slot raises `free` from the next cycle only.
- `rsp_*` present the FIFO head combinationally. When empty: `rsp_valid`=0, `rsp_p`=0, `rsp_id`=0, `rsp_con`=0.
- Flush (edge with `flush`=1):
  - Clears all tag valids and the FIFO pointers/count; `rr` ← 0.
  - No accept and no pop occur that edge.
  - `mul_error` = 1 for exactly the following cycle.
- `busy` = |tag valids | (fifo_count ≠ 0).

## Timing
- Reset (`rst` low, asynchronous): everything below holds immediately and until the first edge after release.
  - `req_ready`=0, `mul_a`=0, `mul_b`=0, `mul_con`=0, `mul_error`=0.
  - `rsp_valid`=0, `rsp_p`=0, `rsp_id`=0, `rsp_con`=0, `busy`=0.
  - FIFO empty, tags cleared, `rr`=0.
- Reset mid-operation discards all work; no response is emitted for it.
- Latency: accept at E0 → FIFO write at E_LAT → `rsp_valid` high in the cycle after E_LAT. That is LAT+1 cycles accept-to-response when the FIFO is empty.
- Throughput: one accept per cycle while `free` > 0.
- Responses return in acceptance order across both requesters.
- Full back-pressure: after DEPTH accepts with no pops, `req_ready`=0 until a pop.
- Flush and `req_valid` in the same cycle: flush wins; the request is not accepted and must be held by the requester.
- `req_ready` depends only on state, `req_valid`, `flush` and `rst`; there is no combinational path from `rsp_ready`.

## Test plan
- Half-mode single op, LAT=2:
  - Stimulus: req0 A=23'h7FFFFF, B=23'h0003FF, con=0.
  - Response: `mul_a`=23'h0003FF (upper bits masked); `rsp_p`=64'h00000000000FF801 with `rsp_id`=0, `rsp_valid` rising 3 cycles after the accept edge.
- Single-mode op:
  - Stimulus: req1 A=23'h7FFFFF, B=23'h000002, con=1.
  - Response: `rsp_p`=64'h0000000000FFFFFE, `rsp_id`=1, `rsp_con`=1.
- Contention:
  - Stimulus: both requesters valid for 6 cycles, `rsp_ready`=1.
  - Response: grants 0,1,0,1,0,1; six responses in the same id order; `busy` low 3 cycles after the last accept.
- Backpressure, DEPTH=4:
  - Stimulus: `rsp_ready`=0 with req0 continuously valid.
  - Response: exactly 4 accepts, then `req_ready`=00. A one-cycle `rsp_ready` pulse yields exactly one further accept, issued in the next cycle.
- Flush with 2 tags in flight and 1 in the FIFO:
  - Stimulus: `flush`=1 for one cycle.
  - Response: no `rsp_valid`; `mul_error` high exactly one cycle; `busy`=0 the cycle after flush; next accept is granted to req0.
- Asynchronous reset mid-stream:
  - Stimulus: drop `rst` between edges.
  - Response: all outputs go to reset values without a clock edge; after release, the first request completes normally.

Source files
------------

// File: rtl/booth_mul_sched_if.sv
// Request, multiplier and response signals shared between the Booth multiplier
// scheduler (slave) and its surrounding stages (master).
interface booth_mul_sched_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [22:0] req0_a;
  logic [22:0] req0_b;
  logic [22:0] req1_a;
  logic [22:0] req1_b;
  logic        req0_con;
  logic        req1_con;
  logic [22:0] mul_a;
  logic [22:0] mul_b;
  logic        mul_con;
  logic        mul_error;
  logic [63:0] mul_p;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic        rsp_con;
  logic [63:0] rsp_p;
  logic        busy;

  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, req0_con, req1_con,
    output mul_p, flush, rsp_ready,
    input  req_ready, mul_a, mul_b, mul_con, mul_error,
    input  rsp_valid, rsp_id, rsp_con, rsp_p, busy
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_con, req1_con,
    input  mul_p, flush, rsp_ready,
    output req_ready, mul_a, mul_b, mul_con, mul_error,
    output rsp_valid, rsp_id, rsp_con, rsp_p, busy
  );
endinterface

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler for the shared Booth/Wallace mantissa multiplier: tracks
// tags through the fixed multiplier latency and buffers products in a credit-checked FIFO.
module booth_mul_sched #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  booth_mul_sched_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + LAT + 1) + 1;

  function automatic logic [22:0] mask_op(input logic [22:0] op, input logic con);
    if (con) begin
      mask_op = op;
    end else begin
      mask_op = {13'd0, op[9:0]};
    end
  endfunction

  function automatic logic [63:0] mask_prod(input logic [63:0] p, input logic con);
    if (con) begin
      mask_prod = p;
    end else begin
      mask_prod = {44'd0, p[19:0]};
    end
  endfunction

  logic          rr_r;
  logic [22:0]   mul_a_r;
  logic [22:0]   mul_b_r;
  logic          mul_con_r;
  logic          mul_error_r;
  logic [LAT:1]  tag_v_r;
  logic [LAT:1]  tag_id_r;
  logic [LAT:1]  tag_con_r;
  logic [63:0]   fifo_p_r   [DEPTH];
  logic          fifo_id_r  [DEPTH];
  logic          fifo_con_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] fifo_cnt_r;

  logic [1:0]    grant_s;
  logic [1:0]    req_ready_s;
  logic [CW-1:0] inflight_s;
  logic          credit_s;
  logic          accept_s;
  logic          acc_id_s;
  logic [22:0]   sel_a_s;
  logic [22:0]   sel_b_s;
  logic          sel_con_s;
  logic          fifo_empty_s;
  logic          push_s;
  logic          pop_s;

  // Round-robin grant: rr names the requester favoured under contention.
  always_comb begin
    grant_s = 2'b00;
    if (bus.req_valid == 2'b11) begin
      grant_s = rr_r ? 2'b10 : 2'b01;
    end else begin
      grant_s = bus.req_valid;
    end
  end

  // Tags currently travelling through the multiplier pipeline.
  always_comb begin
    inflight_s = {CW{1'b0}};
    for (int i = 1; i <= LAT; i++) begin
      inflight_s = inflight_s + CW'(tag_v_r[i]);
    end
  end

  // Every accepted op already owns a FIFO slot, so a full FIFO can never be overrun.
  assign credit_s     = (fifo_cnt_r + inflight_s) < CW'(DEPTH);
  assign req_ready_s  = grant_s & {2{credit_s & ~bus.flush & rst}};
  assign accept_s     = |(bus.req_valid & req_ready_s);
  assign acc_id_s     = grant_s[1];
  assign sel_a_s      = acc_id_s ? bus.req1_a   : bus.req0_a;
  assign sel_b_s      = acc_id_s ? bus.req1_b   : bus.req0_b;
  assign sel_con_s    = acc_id_s ? bus.req1_con : bus.req0_con;

  assign fifo_empty_s = (fifo_cnt_r == {CW{1'b0}});
  assign push_s       = tag_v_r[LAT] & ~bus.flush;
  assign pop_s        = ~fifo_empty_s & bus.rsp_ready & ~bus.flush;

  // Operand/mode registers toward the multiplier, arbiter pointer and kill pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_r        <= 1'b0;
      mul_a_r     <= 23'd0;
      mul_b_r     <= 23'd0;
      mul_con_r   <= 1'b0;
      mul_error_r <= 1'b0;
    end else begin
      mul_error_r <= bus.flush;
      if (bus.flush) begin
        rr_r <= 1'b0;
      end else if (accept_s) begin
        rr_r      <= ~acc_id_s;
        mul_a_r   <= mask_op(sel_a_s, sel_con_s);
        mul_b_r   <= mask_op(sel_b_s, sel_con_s);
        mul_con_r <= sel_con_s;
      end
    end
  end

  // Tag shift register aligned with the multiplier latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v_r   <= {LAT{1'b0}};
      tag_id_r  <= {LAT{1'b0}};
      tag_con_r <= {LAT{1'b0}};
    end else if (bus.flush) begin
      tag_v_r <= {LAT{1'b0}};
    end else begin
      tag_v_r[1]   <= accept_s;
      tag_id_r[1]  <= acc_id_s;
      tag_con_r[1] <= sel_con_s;
      for (int i = 2; i <= LAT; i++) begin
        tag_v_r[i]   <= tag_v_r[i-1];
        tag_id_r[i]  <= tag_id_r[i-1];
        tag_con_r[i] <= tag_con_r[i-1];
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fifo_cnt_r <= {CW{1'b0}};
    end else if (bus.flush) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fifo_cnt_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      fifo_cnt_r <= fifo_cnt_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Result storage; stale entries are hidden by the empty check, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_p_r[wr_ptr_r]   <= mask_prod(bus.mul_p, tag_con_r[LAT]);
      fifo_id_r[wr_ptr_r]  <= tag_id_r[LAT];
      fifo_con_r[wr_ptr_r] <= tag_con_r[LAT];
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.mul_a     = mul_a_r;
  assign bus.mul_b     = mul_b_r;
  assign bus.mul_con   = mul_con_r;
  assign bus.mul_error = mul_error_r;
  assign bus.rsp_valid = ~fifo_empty_s;
  assign bus.rsp_p     = fifo_empty_s ? 64'd0 : fifo_p_r[rd_ptr_r];
  assign bus.rsp_id    = fifo_empty_s ? 1'b0  : fifo_id_r[rd_ptr_r];
  assign bus.rsp_con   = fifo_empty_s ? 1'b0  : fifo_con_r[rd_ptr_r];
  assign bus.busy      = (|tag_v_r) | ~fifo_empty_s;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed and random bench for booth_mul_sched against a queue-based reference model.
module tb_booth_mul_sched;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic        id;
    logic        con;
    logic [63:0] p;
    int          rdy;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  booth_mul_sched_if bus ();

  booth_mul_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: LAT-1 = 1 register stage after mul_a/mul_b.
  logic [63:0] mul_pipe;
  always @(posedge clk) mul_pipe <= 64'(bus.mul_a) * 64'(bus.mul_b);
  assign bus.mul_p = mul_pipe;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_count = 0;
  bit          rr_m = 1'b0;
  bit          last_id = 1'b0;
  rsp_t        q[$];
  logic [22:0] ea = 23'd0;
  logic [22:0] eb = 23'd0;
  logic        econ = 1'b0;
  logic        eerr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rr_m = 1'b0;
    ea = 23'd0;
    eb = 23'd0;
    econ = 1'b0;
    eerr = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, predict the next edge, return at posedge+1.
  task automatic step();
    logic [1:0]  eg;
    logic [1:0]  erdy;
    logic        head_v;
    logic        id;
    logic [22:0] a;
    logic [22:0] b;
    logic        con;
    rsp_t        r;
    @(negedge clk);
    head_v = (q.size() > 0) && (cyc >= q[0].rdy);
    if (bus.req_valid == 2'b11) eg = rr_m ? 2'b10 : 2'b01;
    else eg = bus.req_valid;
    erdy = (bus.flush || q.size() >= DEPTH) ? 2'b00 : eg;
    chk("req_ready", 64'(bus.req_ready), 64'(erdy));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(head_v));
    if (head_v) begin
      chk("rsp_p", bus.rsp_p, q[0].p);
      chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
      chk("rsp_con", 64'(bus.rsp_con), 64'(q[0].con));
    end else begin
      chk("rsp_p_empty", bus.rsp_p, 64'd0);
      chk("rsp_id_empty", 64'({bus.rsp_id, bus.rsp_con}), 64'd0);
    end
    chk("busy", 64'(bus.busy), 64'(q.size() > 0));
    chk("mul_a", 64'(bus.mul_a), 64'(ea));
    chk("mul_b", 64'(bus.mul_b), 64'(eb));
    chk("mul_con", 64'(bus.mul_con), 64'(econ));
    chk("mul_error", 64'(bus.mul_error), 64'(eerr));
    eerr = bus.flush;
    if (bus.flush) begin
      q.delete();
      rr_m = 1'b0;
    end else begin
      if (head_v && bus.rsp_ready) void'(q.pop_front());
      if (erdy != 2'b00) begin
        id  = erdy[1];
        a   = id ? bus.req1_a : bus.req0_a;
        b   = id ? bus.req1_b : bus.req0_b;
        con = id ? bus.req1_con : bus.req0_con;
        ea  = con ? a : 23'(a % 1024);
        eb  = con ? b : 23'(b % 1024);
        econ = con;
        r.id  = id;
        r.con = con;
        r.p   = 64'(ea) * 64'(eb);
        r.rdy = cyc + LAT + 1;
        q.push_back(r);
        rr_m = ~id;
        last_id = id;
        acc_count++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [22:0] a0, input logic [22:0] b0,
                         input logic c0, input logic [22:0] a1, input logic [22:0] b1,
                         input logic c1);
    bus.req_valid = v;
    bus.req0_a = a0; bus.req0_b = b0; bus.req0_con = c0;
    bus.req1_a = a1; bus.req1_b = b1; bus.req1_con = c1;
  endtask

  initial begin
    int n0;
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(2'b01, 23'h1, 23'h1, 1'b1, 23'h0, 23'h0, 1'b0);
    #2;
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_mul", 64'({bus.mul_a, bus.mul_b, bus.mul_con, bus.mul_error}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    set_req(2'b00, 23'h0, 23'h0, 1'b0, 23'h0, 23'h0, 1'b0);
    step();

    // Half-mode op from req0: upper operand bits masked.
    set_req(2'b01, 23'h7FFFFF, 23'h0003FF, 1'b0, 23'h0, 23'h0, 1'b0);
    step();
    set_req(2'b00, 23'h0, 23'h0, 1'b0, 23'h0, 23'h0, 1'b0);
    chk("tp_half_mul_a", 64'(bus.mul_a), 64'h3FF);
    step();
    chk("tp_half_not_yet", 64'(bus.rsp_valid), 64'd0);
    step();
    chk("tp_half_valid", 64'(bus.rsp_valid), 64'd1);
    chk("tp_half_p", bus.rsp_p, 64'h00000000000FF801);
    chk("tp_half_id", 64'(bus.rsp_id), 64'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Single-mode op from req1.
    set_req(2'b10, 23'h0, 23'h0, 1'b0, 23'h7FFFFF, 23'h000002, 1'b1);
    step();
    set_req(2'b00, 23'h0, 23'h0, 1'b0, 23'h0, 23'h0, 1'b0);
    repeat (2) step();
    chk("tp_single_p", bus.rsp_p, 64'h0000000000FFFFFE);
    chk("tp_single_id_con", 64'({bus.rsp_id, bus.rsp_con}), 64'd3);
    bus.rsp_ready = 1'b1;
    step();

    // Contention: alternating grants starting with req0.
    for (int i = 0; i < 6; i++) begin
      set_req(2'b11, 23'(i + 3), 23'(i + 5), 1'b1, 23'(i + 100), 23'(i + 7), 1'b0);
      step();
      chk("tp_grant_order", 64'(last_id), 64'(i % 2));
    end
    set_req(2'b00, 23'h0, 23'h0, 1'b0, 23'h0, 23'h0, 1'b0);
    repeat (2) step();
    chk("tp_busy_tail", 64'(bus.busy), 64'd1);
    step();
    chk("tp_busy_low", 64'(bus.busy), 64'd0);

    // Backpressure: exactly DEPTH accepts, then one more per freed slot.
    bus.rsp_ready = 1'b0;
    set_req(2'b01, 23'h12345, 23'h54321, 1'b1, 23'h0, 23'h0, 1'b0);
    n0 = acc_count;
    repeat (10) step();
    chk("tp_bp_accepts", 64'(acc_count - n0), 64'd4);
    chk("tp_bp_ready_low", 64'(bus.req_ready), 64'd0);
    bus.rsp_ready = 1'b1;
    n0 = acc_count;
    step();
    bus.rsp_ready = 1'b0;
    repeat (4) step();
    chk("tp_bp_one_more", 64'(acc_count - n0), 64'd1);
    set_req(2'b00, 23'h0, 23'h0, 1'b0, 23'h0, 23'h0, 1'b0);
    bus.rsp_ready = 1'b1;
    repeat (8) step();

    // Flush with 2 tags in flight and 1 product buffered.
    bus.rsp_ready = 1'b0;
    set_req(2'b01, 23'h0ABCD, 23'h00777, 1'b1, 23'h1, 23'h1, 1'b1);
    repeat (3) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("tp_flush_err", 64'(bus.mul_error), 64'd1);
    chk("tp_flush_busy", 64'(bus.busy), 64'd0);
    chk("tp_flush_rsp", 64'(bus.rsp_valid), 64'd0);
    set_req(2'b11, 23'h00055, 23'h00066, 1'b0, 23'h00011, 23'h00022, 1'b1);
    step();
    chk("tp_flush_err_off", 64'(bus.mul_error), 64'd0);
    chk("tp_flush_grant0", 64'(last_id), 64'd0);
    set_req(2'b00, 23'h0, 23'h0, 1'b0, 23'h0, 23'h0, 1'b0);
    bus.rsp_ready = 1'b1;
    repeat (5) step();

    // Asynchronous reset between edges with work outstanding.
    bus.rsp_ready = 1'b0;
    set_req(2'b01, 23'h00F0F, 23'h00303, 1'b1, 23'h0, 23'h0, 1'b0);
    repeat (3) step();
    #2;
    rst = 1'b0;
    #1;
    chk("tp_arst_ready", 64'(bus.req_ready), 64'd0);
    chk("tp_arst_rsp", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_con}), 64'd0);
    chk("tp_arst_p", bus.rsp_p, 64'd0);
    chk("tp_arst_busy", 64'(bus.busy), 64'd0);
    chk("tp_arst_mul", 64'({bus.mul_a, bus.mul_b, bus.mul_con, bus.mul_error}), 64'd0);
    model_reset();
    set_req(2'b00, 23'h0, 23'h0, 1'b0, 23'h0, 23'h0, 1'b0);
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b1;
    set_req(2'b10, 23'h0, 23'h0, 1'b0, 23'h001FF, 23'h00100, 1'b1);
    step();
    set_req(2'b00, 23'h0, 23'h0, 1'b0, 23'h0, 23'h0, 1'b0);
    repeat (2) step();
    chk("tp_arst_after_p", bus.rsp_p, 64'h000000000001FF00);
    bus.rsp_ready = 1'b1;
    step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set_req(2'($urandom), 23'($urandom), 23'($urandom), 1'($urandom),
              23'($urandom), 23'($urandom), 1'($urandom));
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      bus.flush = ($urandom_range(0, 29) == 0);
      step();
    end
    bus.flush = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(2'b00, 23'h0, 23'h0, 1'b0, 23'h0, 23'h0, 1'b0);
    repeat (10) step();
    chk("final_busy", 64'(bus.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
